// File: rtl/inst_fetch.sv
// Fetch stage: holds the PC, issues credit-limited requests to instruction
// memory and buffers responses for decode. Optional macro: FETCH_STALL_CNT_EN.
module inst_fetch #(
    parameter int unsigned      Width      = 32,
    parameter logic [Width-1:0] RESET_PC   = '0,
    parameter int unsigned      FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [Width-1:0] imem_addr,
    input  logic             imem_ready,
    input  logic             imem_rvalid,
    input  logic [Width-1:0] imem_rdata,
    input  logic             redirect_valid,
    input  logic [Width-1:0] redirect_pc,
    output logic             inst_valid,
    output logic [Width-1:0] inst,
    output logic [Width-1:0] inst_pc,
    input  logic             inst_ready
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0]      stall_cnt
`endif
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [Width-1:0] r_pc;
    logic [Width-1:0] r_resp_pc;
    logic [CntW-1:0]  r_outst;
    logic [CntW-1:0]  r_drop;
    logic [CntW-1:0]  r_cnt;
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [Width-1:0] r_mem_inst [FIFO_DEPTH];
    logic [Width-1:0] r_mem_pc   [FIFO_DEPTH];
    logic [Width-1:0] r_hold_inst;
    logic [Width-1:0] r_hold_pc;

    logic             w_fifo_empty;
    logic             w_fifo_full;
    logic             w_credit;
    logic             w_accept;
    logic             w_pop;
    logic             w_push;
    logic [CntW-1:0]  w_outst_nxt;
    logic [CntW-1:0]  w_drop_nxt;
    logic [Width-1:0] w_redir_pc;

    assign w_fifo_empty = (r_cnt == '0);
    assign w_fifo_full  = (r_cnt == CntW'(FIFO_DEPTH));
    assign w_credit     = ((CntW + 1)'(r_outst) + (CntW + 1)'(r_cnt)) < (CntW + 1)'(FIFO_DEPTH);
    assign w_accept     = imem_req && imem_ready;
    assign w_pop        = !w_fifo_empty && inst_ready;
    assign w_push       = imem_rvalid && (r_drop == '0) && !w_fifo_full;
    assign w_redir_pc   = redirect_pc & ~Width'(3);

    assign imem_addr  = r_pc;
    assign inst_valid = !w_fifo_empty;
    assign inst       = w_fifo_empty ? r_hold_inst : r_mem_inst[r_rd_ptr];
    assign inst_pc    = w_fifo_empty ? r_hold_pc   : r_mem_pc[r_rd_ptr];

    // Outstanding/drop bookkeeping; both saturate at zero
    always_comb begin
        w_outst_nxt = r_outst;
        if (w_accept) begin
            w_outst_nxt = w_outst_nxt + CntW'(1);
        end
        if (imem_rvalid && (r_outst != '0)) begin
            w_outst_nxt = w_outst_nxt - CntW'(1);
        end
        w_drop_nxt = r_drop;
        if (redirect_valid) begin
            w_drop_nxt = w_outst_nxt;
        end else if (imem_rvalid && (r_drop != '0)) begin
            w_drop_nxt = r_drop - CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        imem_req    = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                imem_req = w_credit;
                if (w_drop_nxt != '0) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_drop_nxt == '0) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_resp_pc   <= RESET_PC;
            r_outst     <= '0;
            r_drop      <= '0;
            r_cnt       <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_hold_inst <= '0;
            r_hold_pc   <= '0;
        end else begin
            r_outst <= w_outst_nxt;
            r_drop  <= w_drop_nxt;
            if (!w_fifo_empty) begin
                r_hold_inst <= r_mem_inst[r_rd_ptr];
                r_hold_pc   <= r_mem_pc[r_rd_ptr];
            end
            if (redirect_valid) begin
                r_pc      <= w_redir_pc;
                r_resp_pc <= w_redir_pc;
                r_cnt     <= '0;
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
            end else begin
                if (w_accept) begin
                    r_pc <= r_pc + Width'(4);
                end
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + Width'(4);
                    r_wr_ptr  <= r_wr_ptr + PtrW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PtrW'(1);
                end
                r_cnt <= r_cnt + CntW'(w_push) - CntW'(w_pop);
            end
        end
    end

    // Buffer storage needs no reset: entries are only read while counted valid
    always_ff @(posedge clk) begin
        if (w_push && !redirect_valid) begin
            r_mem_inst[r_wr_ptr] <= imem_rdata;
            r_mem_pc[r_wr_ptr]   <= r_resp_pc;
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if ((r_state == ST_RUN) && !inst_valid && !redirect_valid) begin
            r_stall_cnt <= r_stall_cnt + 32'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized bench for inst_fetch against a queue-based model of the fetch
// stage and an in-order instruction memory.
module tb_inst_fetch;

    localparam int unsigned W     = 32;
    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic          clk;
    logic          rst;
    logic          imem_req;
    logic [W-1:0]  imem_addr;
    logic          imem_ready;
    logic          imem_rvalid;
    logic [W-1:0]  imem_rdata;
    logic          redirect_valid;
    logic [W-1:0]  redirect_pc;
    logic          inst_valid;
    logic [W-1:0]  inst;
    logic [W-1:0]  inst_pc;
    logic          inst_ready;
`ifdef FETCH_STALL_CNT_EN
    logic [31:0]   stall_cnt;
`endif

    inst_fetch #(.Width(W), .RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [31:0] pc;
    } ent_t;

    typedef struct {
        logic [31:0] data;
        int          acc_cyc;
    } mreq_t;

    ent_t        m_fifo[$];
    mreq_t       m_mem[$];
    logic [31:0] m_pc;
    logic [31:0] m_rpc;
    logic [31:0] m_last_inst;
    logic [31:0] m_last_pc;
    int          m_outst;
    int          m_drop;
    bit          m_boot;
    int          cyc;
    int          n_checks;
    int          n_errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic reset_model();
        m_fifo.delete();
        m_mem.delete();
        m_pc        = RPC;
        m_rpc       = RPC;
        m_last_inst = '0;
        m_last_pc   = '0;
        m_outst     = 0;
        m_drop      = 0;
        m_boot      = 1'b1;
        cyc         = 0;
    endtask

    // One clock cycle: compare outputs with the model, drive inputs, advance the model.
    task automatic step(input bit rdy, input bit irdy, input bit redir,
                        input logic [31:0] tgt, input int rprob);
        bit    exp_req;
        bit    rv;
        mreq_t r;
        ent_t  e;
        int    pre_size;
        exp_req = !m_boot && (m_drop == 0) && ((m_outst + m_fifo.size()) < DEPTH);
        check("imem_req", 32'(imem_req), 32'(exp_req));
        if (imem_req) check("imem_addr", imem_addr, m_pc);
        check("inst_valid", 32'(inst_valid), 32'(m_fifo.size() > 0));
        if (m_fifo.size() > 0) begin
            check("inst", inst, m_fifo[0].data);
            check("inst_pc", inst_pc, m_fifo[0].pc);
            m_last_inst = m_fifo[0].data;
            m_last_pc   = m_fifo[0].pc;
        end else begin
            check("inst_hold", inst, m_last_inst);
            check("inst_pc_hold", inst_pc, m_last_pc);
        end

        rv = (m_mem.size() > 0) && (m_mem[0].acc_cyc < cyc) && ($urandom_range(99) < rprob);
        imem_ready     = rdy;
        inst_ready     = irdy;
        redirect_valid = redir;
        redirect_pc    = tgt;
        imem_rvalid    = rv;
        imem_rdata     = rv ? m_mem[0].data : $urandom;
        #1;

        pre_size = m_fifo.size();
        if (rv) r = m_mem.pop_front();
        if (exp_req && rdy) begin
            m_mem.push_back('{data: $urandom, acc_cyc: cyc});
            m_pc = m_pc + 32'd4;
            m_outst++;
        end
        if ((m_fifo.size() > 0) && irdy) void'(m_fifo.pop_front());
        if (rv) begin
            if (m_outst > 0) m_outst--;
            if (m_drop > 0) begin
                m_drop--;
            end else if (pre_size < DEPTH) begin
                e.data = r.data;
                e.pc   = m_rpc;
                m_fifo.push_back(e);
                m_rpc = m_rpc + 32'd4;
            end
        end
        if (redir) begin
            m_fifo.delete();
            m_pc   = tgt & ~32'd3;
            m_rpc  = m_pc;
            m_drop = m_outst;
        end
        m_boot = 1'b0;
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        imem_ready     = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, 32'(imem_req), 32'd0);
        check({tag, "_valid"}, 32'(inst_valid), 32'd0);
        check({tag, "_inst"}, inst, 32'd0);
        check({tag, "_pc"}, inst_pc, 32'd0);
`ifdef FETCH_STALL_CNT_EN
        check({tag, "_stall"}, stall_cnt, 32'd0);
`endif
    endtask

    initial begin
        int first;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        idle_inputs();
        reset_model();
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;

        // Streaming with single-cycle memory: first instruction after 3 edges
        first = -1;
        for (int i = 0; i < 12; i++) begin
            if (inst_valid && first < 0) first = i;
            step(1'b1, 1'b1, 1'b0, '0, 100);
        end
        check("first_valid_latency", 32'(first), 32'd3);

        // Decode stall: credit limits fetch, buffered PCs pop in order later
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, '0, 100);
        for (int i = 0; i < 6; i++)  step(1'b1, 1'b1, 1'b0, '0, 100);

        // Two requests in flight, then redirect to a misaligned target
        for (int i = 0; i < 4; i++)  step(1'b1, 1'b1, 1'b0, '0, 0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_1002, 0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, '0, 100);

        // Response coinciding with a redirect while one request is in flight
        for (int i = 0; i < 4; i++)  step(1'b0, 1'b1, 1'b0, '0, 100);
        step(1'b1, 1'b1, 1'b0, '0, 0);
        step(1'b0, 1'b1, 1'b1, 32'h0000_2000, 100);
        for (int i = 0; i < 8; i++)  step(1'b1, 1'b1, 1'b0, '0, 100);

        // Address wrap at the top of the address space
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF4, 100);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, '0, 100);

        // Random traffic with occasional redirects, some near the wrap point
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
            step($urandom_range(99) < 75, $urandom_range(99) < 70,
                 $urandom_range(99) < 3, tgt, 60);
        end

        // Asynchronous reset mid-stream with requests in flight
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, '0, 0);
        #2;
        rst = 1'b1;
        idle_inputs();
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(99) < 80, $urandom_range(99) < 70,
                 $urandom_range(99) < 2, $urandom, 70);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
